// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch run/pause/clear sequencer.
package stopwatch_pkg;

    // Run-state encoding of the stopwatch sequencer.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_e;

    // Largest value a single BCD digit may hold.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Clock cycles per 10 ms tick at 100 MHz.
    localparam int unsigned TICK_DIV = 32'd1000000;

    // True when all four packed BCD digits read 99.99.
    function automatic logic is_max_count(input logic [15:0] digits);
        is_max_count = (digits[3:0]   == BCD_MAX) &&
                       (digits[7:4]   == BCD_MAX) &&
                       (digits[11:8]  == BCD_MAX) &&
                       (digits[15:12] == BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single 0-9 BCD counter stage; stages are chained through CarryOut -> Inc.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Inc,
    input  logic       Clr,
    output logic [3:0] Value,
    output logic       CarryOut
);

    logic [3:0] value_r;

    // Digit register: clear has priority, otherwise increment with wrap at 9.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            value_r <= 4'd0;
        end else if (Clr) begin
            value_r <= 4'd0;
        end else if (Inc) begin
            if (value_r >= BCD_MAX) begin
                value_r <= 4'd0;
            end else begin
                value_r <= value_r + 4'd1;
            end
        end else begin
            value_r <= value_r;
        end
    end

    assign Value    = value_r;
    assign CarryOut = Inc && (value_r == BCD_MAX);

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch run/pause/clear sequencer, 10 ms timebase and 4-digit BCD count.
// Optional lap-hold display freeze is enabled by defining STOPWATCH_LAP_HOLD_EN.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int unsigned TickDiv = TICK_DIV
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Start,
    input  logic       Stop,
    input  logic       Clear,
`ifdef STOPWATCH_LAP_HOLD_EN
    input  logic       Lap,
`endif
    output logic [3:0] Digit0,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [3:0] Digit3,
    output logic       Running,
    output logic       Overflow
);

    localparam logic [31:0] TICK_LAST = 32'(TickDiv - 32'd1);

    sw_state_e   state_r;
    sw_state_e   state_next_s;
    logic        start_q_r;
    logic        stop_q_r;
    logic        clear_q_r;
    logic        start_edge_s;
    logic        stop_edge_s;
    logic        clear_edge_s;
    logic [31:0] prescaler_r;
    logic        tick_s;
    logic        at_max_s;
    logic        running_r;
    logic        overflow_r;
    logic [3:0]  live_s [4];
    logic [3:0]  inc_s;
    logic [2:0]  carry_s;
    logic        carry3_unused_s;
    logic [15:0] live_packed_s;

    // Button history; loads 1 on reset so a button held through reset never fires.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            start_q_r <= 1'b1;
            stop_q_r  <= 1'b1;
            clear_q_r <= 1'b1;
        end else begin
            start_q_r <= Start;
            stop_q_r  <= Stop;
            clear_q_r <= Clear;
        end
    end

    assign start_edge_s = Start & ~start_q_r;
    assign stop_edge_s  = Stop  & ~stop_q_r;
    assign clear_edge_s = Clear & ~clear_q_r;

    assign live_packed_s = {live_s[3], live_s[2], live_s[1], live_s[0]};
    assign at_max_s      = is_max_count(live_packed_s);
    assign tick_s        = (state_r == RUNNING) && (prescaler_r == TICK_LAST);

    // Run-state register.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: Clear beats Stop beats Start; saturation forces a pause.
    always_comb begin
        state_next_s = state_r;
        if (clear_edge_s) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_edge_s) begin
                        state_next_s = RUNNING;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                RUNNING: begin
                    if (tick_s && at_max_s) begin
                        state_next_s = PAUSED;
                    end else if (stop_edge_s) begin
                        state_next_s = PAUSED;
                    end else begin
                        state_next_s = RUNNING;
                    end
                end
                PAUSED: begin
                    if (start_edge_s && !overflow_r) begin
                        state_next_s = RUNNING;
                    end else begin
                        state_next_s = PAUSED;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // Running flag is a registered decode of the upcoming state.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            running_r <= 1'b0;
        end else begin
            running_r <= (state_next_s == RUNNING);
        end
    end

    // Prescaler counts only while running and keeps its partial tick over a pause.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            prescaler_r <= 32'd0;
        end else if (clear_edge_s || (state_r == IDLE)) begin
            prescaler_r <= 32'd0;
        end else if (state_r == RUNNING) begin
            if (tick_s) begin
                prescaler_r <= 32'd0;
            end else begin
                prescaler_r <= prescaler_r + 32'd1;
            end
        end else begin
            prescaler_r <= prescaler_r;
        end
    end

    // Sticky saturation flag, set by a tick arriving at 99.99.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            overflow_r <= 1'b0;
        end else if (clear_edge_s) begin
            overflow_r <= 1'b0;
        end else if (tick_s && at_max_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Saturating tick must not advance the chain, so the first stage is gated.
    assign inc_s[0] = tick_s && !at_max_s;
    assign inc_s[1] = carry_s[0];
    assign inc_s[2] = carry_s[1];
    assign inc_s[3] = carry_s[2];

    bcd_digit u_digit0 (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Inc      (inc_s[0]),
        .Clr      (clear_edge_s),
        .Value    (live_s[0]),
        .CarryOut (carry_s[0])
    );

    bcd_digit u_digit1 (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Inc      (inc_s[1]),
        .Clr      (clear_edge_s),
        .Value    (live_s[1]),
        .CarryOut (carry_s[1])
    );

    bcd_digit u_digit2 (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Inc      (inc_s[2]),
        .Clr      (clear_edge_s),
        .Value    (live_s[2]),
        .CarryOut (carry_s[2])
    );

    // Top digit's carry can never fire because saturation gates the chain.
    bcd_digit u_digit3 (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Inc      (inc_s[3]),
        .Clr      (clear_edge_s),
        .Value    (live_s[3]),
        .CarryOut (carry3_unused_s)
    );

    assign Running  = running_r;
    assign Overflow = overflow_r;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap_q_r;
    logic        lap_edge_s;
    logic        hold_r;
    logic [15:0] snap_r;

    // Lap button history, same reset behaviour as the other buttons.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            lap_q_r <= 1'b1;
        end else begin
            lap_q_r <= Lap;
        end
    end

    assign lap_edge_s = Lap & ~lap_q_r;

    // Hold flag and snapshot; Clear releases the hold ahead of any Lap press.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            hold_r <= 1'b0;
            snap_r <= 16'd0;
        end else if (clear_edge_s) begin
            hold_r <= 1'b0;
            snap_r <= snap_r;
        end else if (lap_edge_s && (state_r == RUNNING)) begin
            hold_r <= ~hold_r;
            if (!hold_r) begin
                snap_r <= live_packed_s;
            end else begin
                snap_r <= snap_r;
            end
        end else begin
            hold_r <= hold_r;
            snap_r <= snap_r;
        end
    end

    assign Digit0 = hold_r ? snap_r[3:0]   : live_s[0];
    assign Digit1 = hold_r ? snap_r[7:4]   : live_s[1];
    assign Digit2 = hold_r ? snap_r[11:8]  : live_s[2];
    assign Digit3 = hold_r ? snap_r[15:12] : live_s[3];
`else
    assign Digit0 = live_s[0];
    assign Digit1 = live_s[1];
    assign Digit2 = live_s[2];
    assign Digit3 = live_s[3];
`endif

endmodule

// File: tb/tb_stopwatch_control.sv
// Directed self-checking bench for stopwatch_control with TickDiv=4.
// Lap-hold steps are included when STOPWATCH_LAP_HOLD_EN is defined.
module tb_stopwatch_control;

    logic        Clock;
    logic        Reset_n;
    logic        Start;
    logic        Stop;
    logic        Clear;
`ifdef STOPWATCH_LAP_HOLD_EN
    logic        Lap;
`endif
    logic [3:0]  Digit0;
    logic [3:0]  Digit1;
    logic [3:0]  Digit2;
    logic [3:0]  Digit3;
    logic        Running;
    logic        Overflow;
    logic [15:0] disp;

    int errors = 0;
    int checks = 0;

    stopwatch_control #(.TickDiv(4)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .Start    (Start),
        .Stop     (Stop),
        .Clear    (Clear),
`ifdef STOPWATCH_LAP_HOLD_EN
        .Lap      (Lap),
`endif
        .Digit0   (Digit0),
        .Digit1   (Digit1),
        .Digit2   (Digit2),
        .Digit3   (Digit3),
        .Running  (Running),
        .Overflow (Overflow)
    );

    assign disp = {Digit3, Digit2, Digit1, Digit0};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    initial begin
        Reset_n = 1'b0;
        Start   = 1'b1;
        Stop    = 1'b0;
        Clear   = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
        Lap     = 1'b0;
`endif
        step(3);
        chk("reset_disp", disp, 16'h0000);
        chk("reset_running", {15'd0, Running}, 16'd0);
        chk("reset_overflow", {15'd0, Overflow}, 16'd0);

        // Start held through reset must not fire.
        Reset_n = 1'b1;
        step(3);
        chk("held_start_ignored", {15'd0, Running}, 16'd0);

        // Fresh press: Running next edge, first tick four cycles later.
        Start = 1'b0;
        step(1);
        Start = 1'b1;
        step(1);
        chk("start_running", {15'd0, Running}, 16'd1);
        Start = 1'b0;
        step(3);
        chk("before_first_tick", disp, 16'h0000);
        step(1);
        chk("first_tick", disp, 16'h0001);

        // Nine more ticks reach 00.10.
        step(36);
        chk("ten_ticks", disp, 16'h0010);

        // Pause with prescaler at 3, stay frozen, resume finishes the partial tick.
        step(2);
        Stop = 1'b1;
        step(1);
        chk("stop_running", {15'd0, Running}, 16'd0);
        Stop = 1'b0;
        step(20);
        chk("paused_frozen", disp, 16'h0010);
        Start = 1'b1;
        step(1);
        chk("resume_running", {15'd0, Running}, 16'd1);
        chk("resume_no_tick_yet", disp, 16'h0010);
        Start = 1'b0;
        step(1);
        chk("resume_partial_tick", disp, 16'h0011);

        // Carry chain through every digit.
        step(352);
        chk("reach_0099", disp, 16'h0099);
        step(4);
        chk("carry_0100", disp, 16'h0100);
        step(3596);
        chk("reach_0999", disp, 16'h0999);
        step(4);
        chk("carry_1000", disp, 16'h1000);
        step(35996);
        chk("reach_9999", disp, 16'h9999);
        chk("reach_9999_ovf", {15'd0, Overflow}, 16'd0);
        step(3);
        chk("pre_sat_running", {15'd0, Running}, 16'd1);
        step(1);
        chk("sat_disp", disp, 16'h9999);
        chk("sat_overflow", {15'd0, Overflow}, 16'd1);
        chk("sat_running", {15'd0, Running}, 16'd0);

        // Start ignored after overflow; Clear resets everything.
        Start = 1'b1;
        step(1);
        chk("ovf_start_ignored", {15'd0, Running}, 16'd0);
        Start = 1'b0;
        step(5);
        chk("ovf_still_9999", disp, 16'h9999);
        Clear = 1'b1;
        step(1);
        chk("clear_disp", disp, 16'h0000);
        chk("clear_overflow", {15'd0, Overflow}, 16'd0);
        Clear = 1'b0;
        step(6);
        chk("clear_idle_no_count", disp, 16'h0000);

        // Run to 05.00 then hit all three buttons together.
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(2000);
        chk("reach_0500", disp, 16'h0500);
        Start = 1'b1;
        Stop  = 1'b1;
        Clear = 1'b1;
        step(1);
        chk("triple_disp", disp, 16'h0000);
        chk("triple_running", {15'd0, Running}, 16'd0);
        Start = 1'b0;
        Stop  = 1'b0;
        Clear = 1'b0;
        step(8);
        chk("triple_idle", disp, 16'h0000);

        // Stop edge coinciding with the tick at 00.03.
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(12);
        chk("reach_0003", disp, 16'h0003);
        step(3);
        Stop = 1'b1;
        step(1);
        chk("stop_tick_disp", disp, 16'h0004);
        chk("stop_tick_running", {15'd0, Running}, 16'd0);
        Stop = 1'b0;
        step(8);
        chk("stop_tick_frozen", disp, 16'h0004);

`ifdef STOPWATCH_LAP_HOLD_EN
        // Lap hold: show 00.05 while the count runs to 00.09, then release.
        Clear = 1'b1;
        step(1);
        Clear = 1'b0;
        Start = 1'b1;
        step(1);
        Start = 1'b0;
        step(20);
        chk("lap_reach_0005", disp, 16'h0005);
        Lap = 1'b1;
        step(1);
        Lap = 1'b0;
        step(15);
        chk("lap_hold_shows_0005", disp, 16'h0005);
        Lap = 1'b1;
        step(1);
        chk("lap_release_0009", disp, 16'h0009);
        Lap = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_control.md
Name: stopwatch_control

Overview:
Run/pause/clear sequencer and timebase for the 4-digit stopwatch. Converts Start/Stop/Clear button levels into a three-state run FSM. Divides Clock down to a 10 ms tick and keeps a 4-digit BCD count from 00.00 to 99.99 s. Its four BCD digits feed the per-digit 7-segment decoders, which in turn drive the display multiplexer.

Parameters:
TickDiv, 32'd1000000, Clock cycles per 10 ms tick (100 MHz); must be >= 2; the bench uses 4.

Ports:
Clock  input  1  system clock, all logic on rising edge
Reset_n  input  1  synchronous active-low reset
Start  input  1  run request, level, already synchronised; acts on rising edge
Stop  input  1  pause request, level, already synchronised; acts on rising edge
Clear  input  1  clear request, level, already synchronised; acts on rising edge
Digit0  output  4  BCD hundredths (0-9)
Digit1  output  4  BCD tenths (0-9)
Digit2  output  4  BCD seconds units (0-9)
Digit3  output  4  BCD seconds tens (0-9)
Running  output  1  high while the FSM is in RUNNING
Overflow  output  1  sticky; count saturated at 99.99

Behaviour:
- Reset (Reset_n low at a rising edge):
  - state=IDLE; all digits 0; Running=0; Overflow=0; prescaler=0.
  - Edge-detect registers load 1, so a button already held during reset does not fire.
- Edge detect: XEdge = X & ~X_q, with X_q registered each cycle. Holding a button fires exactly once.
- Priority for same-cycle edges: Clear > Stop > Start.
- FSM states and transitions:
  - IDLE: StartEdge -> RUNNING.
  - RUNNING: StopEdge -> PAUSED.
  - PAUSED: StartEdge -> RUNNING, unless Overflow=1 (Start ignored).
  - Any state: ClearEdge -> IDLE; digits, prescaler and Overflow all zeroed on the same edge.
  - Stop in IDLE/PAUSED and Start in RUNNING are ignored.
- Running is a registered decode of the state. It rises on the clock edge that samples StartEdge.
- Prescaler:
  - Counts 0..TickDiv-1, only in RUNNING.
  - Holds its value in PAUSED, so the partial tick is kept across a pause.
  - Cleared in IDLE.
  - Tick is asserted in the cycle where prescaler==TickDiv-1 and state==RUNNING. The prescaler wraps to 0 on that cycle.
- First tick arrives TickDiv cycles after entering RUNNING from IDLE.
- Digit chain (BCD ripple), updated on the edge that samples Tick:
  - Digit0 increments; at 9 it wraps to 0 and carries into Digit1.
  - Digit1 -> Digit2 and Digit2 -> Digit3 carry the same way.
  - Digits never leave 0-9.
- Saturation: a Tick while the count is 99.99 leaves the digits at 99.99, sets Overflow=1 and moves the FSM to PAUSED on that same edge.
- Stop coinciding with a Tick: the tick's increment is applied, then the FSM moves to PAUSED.
- Clear coinciding with a Tick: Clear wins and digits go to 0.
- Reset asserted mid-run: behaves as full reset on that edge.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- Defined:
  - Adds input Lap (1 bit, level, edge-detected like the other buttons).
  - LapEdge in RUNNING toggles a Hold flag.
  - While Hold=1, Digit0-3 show a snapshot taken on the edge Hold was set; the internal count keeps running.
  - LapEdge again, or ClearEdge, clears Hold and the live count reappears next cycle.
  - Hold survives Stop.
  - Lap is lowest priority among the buttons.
- Undefined: no Lap port, no snapshot registers; the digits always show the live count.

Decomposition:
- Package stopwatch_pkg holds:
  - state encoding IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2;
  - BCD_MAX=4'd9;
  - default TICK_DIV constant.
- One sub-module, bcd_digit: a single 0-9 counter with inputs Inc, Clr and outputs Value[3:0], CarryOut (Inc && Value==9). It is instantiated four times in a carry chain.

Test Plan (TickDiv=4):
- Reset with Start held high -> state stays IDLE, no Running pulse; release then press Start -> Running=1 next edge, Digit0=1 exactly 4 cycles later.
- Run 10 ticks -> Digit1=1, Digit0=0; Stop, idle 20 cycles -> digits frozen at 00.10; Start -> next increment after the remaining prescaler cycles, not a full 4.
- Preload-by-run to 00.99, one tick -> 01.00; continue to 09.99 -> 10.00 (carry through every digit).
- Run to 99.99, one more tick -> digits stay 99.99, Overflow=1, Running=0; Start ignored; Clear -> 00.00, Overflow=0, IDLE.
- Start, Stop and Clear rising together while RUNNING at 05.00 -> IDLE, 00.00; a Stop edge coinciding with a tick at 00.03 -> 00.04, PAUSED.
- With STOPWATCH_LAP_HOLD_EN: Lap at 00.05 -> outputs hold 00.05 while internal count reaches 00.09; Lap again -> outputs show 00.09 next cycle.
